gpio_key_irq_ctrl: RTL

Key-input controller for the board GPIO resource. It synchronizes and debounces the eight raw `user_key` lines and detects press and release events. It latches those events into pending bits and raises a masked interrupt request to the CPU's CP0 external-interrupt input. It sits beside the GPIO block on the bridge and decodes its own 16-byte register window, so polled key reads are replaced by clean, edge-qualified events.

---
 rtl/gpio_key_irq_ctrl_if.sv | 11 +
 rtl/gpio_key_irq_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/gpio_key_irq_ctrl_if.sv
// Bridge-side register window of the key controller: address, byte-lane write enables and data,
// plus the combinational read-back.
interface gpio_key_irq_ctrl_if;
  logic [31:0] IRQ_Addr;
  logic [3:0]  IRQ_WE;
  logic [31:0] IRQ_WriteData;
  logic [31:0] IRQ_ReadData;

  modport master (output IRQ_Addr, output IRQ_WE, output IRQ_WriteData, input IRQ_ReadData);
  modport slave  (input IRQ_Addr, input IRQ_WE, input IRQ_WriteData, output IRQ_ReadData);
endinterface

// File: rtl/gpio_key_irq_ctrl.sv
// Eight-key synchronizer/debouncer with press/release event latching, a press counter and a
// masked level interrupt, exposed through a 4-word register window.
module gpio_key_irq_ctrl #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [7:0]                user_key,
  gpio_key_irq_ctrl_if.slave        bus,
  output logic [7:0]                key_state,
  output logic                      irq
);
  localparam int PW = $clog2(SAMPLE_DIV);

  logic [7:0]      sync1_reg, sync2_reg, pressed_sync;
  logic [PW-1:0]   presc_reg;
  logic            tick;
  logic [7:0][2:0] dcnt_reg, dcnt_next;
  logic [7:0]      key_state_reg, key_state_next, prev_key_reg;
  logic [7:0]      press, rel;
  logic [15:0]     pend_reg, pend_next, pend_clr;
  logic [15:0]     mask_reg, mask_next;
  logic [15:0]     cnt_reg, cnt_next, press_cnt;
  logic [1:0]      sel;
  logic            we0, we1;
  logic            unused_bits;

  assign pressed_sync = ~sync2_reg;
  assign tick         = (presc_reg == PW'(SAMPLE_DIV - 1));

  // Per-key debounce: a toggle needs STABLE_CNT consecutive mismatching ticks.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_deb
      logic mism, hit;
      assign mism = pressed_sync[gi] ^ key_state_reg[gi];
      assign hit  = tick & mism & (dcnt_reg[gi] == 3'(STABLE_CNT - 1));
      assign key_state_next[gi] = key_state_reg[gi] ^ hit;
      assign dcnt_next[gi] = !tick          ? dcnt_reg[gi] :
                             (!mism || hit) ? 3'd0 : dcnt_reg[gi] + 3'd1;
    end
  endgenerate

  assign press = key_state_reg & ~prev_key_reg;
  assign rel   = ~key_state_reg & prev_key_reg;

  assign sel = bus.IRQ_Addr[3:2];
  assign we0 = bus.IRQ_WE[0];
  assign we1 = bus.IRQ_WE[1];

  always_comb begin
    press_cnt = '0;
    for (int i = 0; i < 8; i++) press_cnt = press_cnt + {15'd0, press[i]};
  end

  // Event set has priority over a same-cycle write-1-to-clear.
  always_comb begin
    pend_clr = '0;
    if (sel == 2'd1) begin
      if (we0) pend_clr[7:0]  = bus.IRQ_WriteData[7:0];
      if (we1) pend_clr[15:8] = bus.IRQ_WriteData[15:8];
    end
    pend_next = (pend_reg & ~pend_clr) | {rel, press};
  end

  always_comb begin
    mask_next = mask_reg;
    if (sel == 2'd2) begin
      if (we0) mask_next[7:0]  = bus.IRQ_WriteData[7:0];
      if (we1) mask_next[15:8] = bus.IRQ_WriteData[15:8];
    end
  end

  assign cnt_next = ((sel == 2'd3 && (we0 || we1)) ? 16'd0 : cnt_reg) + press_cnt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_reg     <= '1;
      sync2_reg     <= '1;
      presc_reg     <= '0;
      dcnt_reg      <= '0;
      key_state_reg <= '0;
      prev_key_reg  <= '0;
      pend_reg      <= '0;
      mask_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      sync1_reg     <= user_key;
      sync2_reg     <= sync1_reg;
      presc_reg     <= tick ? '0 : presc_reg + 1'b1;
      dcnt_reg      <= dcnt_next;
      key_state_reg <= key_state_next;
      prev_key_reg  <= key_state_reg;
      pend_reg      <= pend_next;
      mask_reg      <= mask_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    bus.IRQ_ReadData = '0;
    case (sel)
      2'd0: bus.IRQ_ReadData = {24'd0, key_state_reg};
      2'd1: bus.IRQ_ReadData = {16'd0, pend_reg};
      2'd2: bus.IRQ_ReadData = {16'd0, mask_reg};
      default: bus.IRQ_ReadData = {16'd0, cnt_reg};
    endcase
  end

  assign key_state = key_state_reg;
  assign irq       = |(pend_reg & mask_reg);

  assign unused_bits = ^{bus.IRQ_Addr[31:4], bus.IRQ_Addr[1:0], bus.IRQ_WE[3:2],
                         bus.IRQ_WriteData[31:16]};
endmodule
